sw_debounce: RTL and testbench
==============================

# sw_debounce

Input conditioner for the board's slide switches and push-buttons: synchronises each raw switch bit into the `clk` domain, debounces it with a per-bit stability counter, and emits a clean level, one-cycle rise/fall pulses and a per-bit toggle state. It sits between the board switch pins and the lab logic modules that drive the LEDs. It is the input-side counterpart of the switch-to-LED datapath, so downstream logic never sees a raw, bouncing pin.

## Interface
- `WIDTH`, default 2: number of independent switch bits.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a new level (10 ms at 100 MHz).
  - Legal range is ≥ 1.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sw`  in  WIDTH: raw, asynchronous switch/button pins.
- `sw_level`  out  WIDTH: debounced level, registered.
- `sw_rise`  out  WIDTH: one-cycle pulse when `sw_level` bit goes 0→1, registered.
- `sw_fall`  out  WIDTH: one-cycle pulse when `sw_level` bit goes 1→0, registered.
- `sw_toggle`  out  WIDTH: per-bit state that inverts on each accepted rise, registered.

## Operation
- All bits are fully independent, each with its own synchroniser, counter and output registers.
- **Synchroniser:** two flops per bit, `s1 <= sw`, `s2 <= s1`. Only `s2` is used downstream.
- **Stability counter** `cnt`, per bit:
  - If `s2 == sw_level`: `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`: accept. `sw_level <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- **Glitch rejection:** any return of `s2` to `sw_level` before acceptance clears `cnt`. A bounce shorter than `DEBOUNCE_CYCLES` cycles never changes `sw_level`.
- **Pulses:**
  - `sw_rise` is 1 for exactly the cycle following an accept of 1. `sw_fall` likewise for an accept of 0.
  - Both are 0 in every other cycle. They are never high together on the same bit.
- **Toggle:** `sw_toggle` inverts on the same edge that sets `sw_rise`. Fall has no effect on it.
- **Counter arithmetic:** unsigned. `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap.
- **`DEBOUNCE_CYCLES = 1`:** `sw_level` follows `s2` with one cycle of delay, and every `s2` change is accepted.

## Timing
- **Reset (`rst_n` low, asynchronous):**
  - `s1`, `s2`, `cnt`, `sw_level`, `sw_rise`, `sw_fall` and `sw_toggle` all clear to 0 immediately.
  - A switch that is held at 1 through reset is therefore accepted as a rise `DEBOUNCE_CYCLES+2` edges after release.
- **Reset release:** takes effect at the first `clk` edge with `rst_n` high.
- **Reset mid-count:** the pending change is discarded and counting restarts from 0.
- **Latency:** let `sw` change and be stable before edge E0.
  - `s2` updates at E1.
  - Acceptance, with `sw_level`, `sw_rise`/`sw_fall` and `sw_toggle` updating, happens at edge E(1+DEBOUNCE_CYCLES).
  - Total is `DEBOUNCE_CYCLES+1` edges after the first sampling edge.
- **Pulse clearing:** pulses drop at the next edge, E(2+DEBOUNCE_CYCLES).
- **Pulse spacing:** minimum spacing between two accepted changes on one bit is `DEBOUNCE_CYCLES` cycles.
- **Simultaneous changes:** on different bits they are processed independently. Pulses may coincide across bits.

## Test plan
Bench uses `WIDTH=2`, `DEBOUNCE_CYCLES=4`, 10 ns clock.
- **Reset:**
  - Stimulus: `rst_n=0` with `sw=2'b11`.
  - Response: all outputs are 0 while in reset. After release, `sw_level=2'b11` at edge 5, with `sw_rise=2'b11` for one cycle and `sw_toggle=2'b11`.
- **Clean press:**
  - Stimulus: `sw[0]` 0→1 held before E0.
  - Response: `sw_level[0]=1` and `sw_rise[0]=1` at E5, `sw_rise[0]=0` at E6, `sw_toggle[0]=1`, and `sw_fall=0` throughout.
- **Bounce rejection:**
  - Stimulus: `sw[1]` pulses high for 3 cycles, three times, separated by 1-cycle lows.
  - Response: `sw_level[1]` stays 0 and no pulses appear. When `sw[1]` is then held high, `sw_rise[1]` fires 5 edges after the last low-to-high change.
- **Press/release/press:**
  - Stimulus: `sw[0]` goes 1 for 10 cycles, then 0 for 10, then 1.
  - Response: sequence `sw_rise`, `sw_fall`, `sw_rise`. `sw_toggle[0]` reads 1, then 1, then 0.
- **Independent bits:**
  - Stimulus: both bits go 0→1 on the same cycle.
  - Response: `sw_rise=2'b11` in a single cycle. Then `sw[1]` alone falls and yields `sw_fall=2'b10`, with `sw_level=2'b01`.
- **Reset mid-count:**
  - Stimulus: `sw[0]` rises, and `rst_n` pulses low 2 cycles later.
  - Response: no pulse before reset. `sw_rise[0]` fires 5 edges after reset release.

Source files
------------

// File: rtl/sw_debounce.sv
// ============================================================================
// Module   : sw_debounce
// Purpose  : Per-bit synchroniser + stability-counter debouncer for switches,
//            producing clean level, rise/fall pulses and a toggle state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_debounce #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] sw_toggle
);

  localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic          r_s1;
    logic          r_s2;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic          r_toggle;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1     <= 1'b0;
        r_s2     <= 1'b0;
        r_cnt    <= '0;
        r_level  <= 1'b0;
        r_rise   <= 1'b0;
        r_fall   <= 1'b0;
        r_toggle <= 1'b0;
      end else begin
        r_s1   <= sw[i];
        r_s2   <= r_s1;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        // Any return to the accepted level restarts the stability window.
        if (r_s2 == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
          r_level <= r_s2;
          r_cnt   <= '0;
          r_rise  <= r_s2;
          r_fall  <= ~r_s2;
          if (r_s2)
            r_toggle <= ~r_toggle;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end

    assign sw_level[i]  = r_level;
    assign sw_rise[i]   = r_rise;
    assign sw_fall[i]   = r_fall;
    assign sw_toggle[i] = r_toggle;
  end

endmodule

`default_nettype wire

// File: tb/tb_sw_debounce.sv
// ============================================================================
// Module   : tb_sw_debounce
// Purpose  : Directed self-checking bench for sw_debounce (WIDTH=2, 4 cycles).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sw_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sw;
  logic [1:0] sw_level;
  logic [1:0] sw_rise;
  logic [1:0] sw_fall;
  logic [1:0] sw_toggle;

  int n_pass  = 0;
  int n_total = 0;

  sw_debounce #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .sw_level (sw_level),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .sw_toggle(sw_toggle)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [1:0] lvl, input logic [1:0] rise,
                         input logic [1:0] fall, input logic [1:0] tog);
    chk({tag, ".level"},  sw_level,  lvl);
    chk({tag, ".rise"},   sw_rise,   rise);
    chk({tag, ".fall"},   sw_fall,   fall);
    chk({tag, ".toggle"}, sw_toggle, tog);
  endtask

  task automatic do_reset(input logic [1:0] v);
    sw    = v;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(8);
  endtask

  initial begin
    // Reset held with both switches high
    rst_n = 1'b0;
    sw    = 2'b11;
    step(3);
    chk_all("rst_hold", 2'b00, 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    step(5);                                     // E0..E4
    chk_all("rst_e4", 2'b00, 2'b00, 2'b00, 2'b00);
    step();                                      // E5
    chk_all("rst_e5", 2'b11, 2'b11, 2'b00, 2'b11);
    step();                                      // E6
    chk_all("rst_e6", 2'b11, 2'b00, 2'b00, 2'b11);

    // Clean press on bit 0
    do_reset(2'b00);
    chk_all("press_idle", 2'b00, 2'b00, 2'b00, 2'b00);
    sw = 2'b01;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("press_nofall", sw_fall, 2'b00);
    end
    chk_all("press_e4", 2'b00, 2'b00, 2'b00, 2'b00);
    step();
    chk_all("press_e5", 2'b01, 2'b01, 2'b00, 2'b01);
    step();
    chk_all("press_e6", 2'b01, 2'b00, 2'b00, 2'b01);

    // Bounce on bit 1: three 3-cycle highs separated by 1-cycle lows
    for (int r = 0; r < 3; r++) begin
      sw = 2'b11;
      for (int k = 0; k < 3; k++) begin
        step();
        chk_all("bounce_hi", 2'b01, 2'b00, 2'b00, 2'b01);
      end
      sw = 2'b01;
      step();
      chk_all("bounce_lo", 2'b01, 2'b00, 2'b00, 2'b01);
    end
    sw = 2'b11;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_all("bounce_hold", 2'b01, 2'b00, 2'b00, 2'b01);
    end
    step();
    chk_all("bounce_e5", 2'b11, 2'b10, 2'b00, 2'b11);
    step();
    chk("bounce_e6.rise", sw_rise, 2'b00);

    // Press / release / press on bit 0
    do_reset(2'b00);
    sw = 2'b01;
    step(6);
    chk_all("prp_rise1", 2'b01, 2'b01, 2'b00, 2'b01);
    step(4);
    sw = 2'b00;
    step(5);
    chk("prp_prefall", sw_level, 2'b01);
    step();
    chk_all("prp_fall", 2'b00, 2'b00, 2'b01, 2'b01);
    step();
    chk("prp_fall_clr", sw_fall, 2'b00);
    step(3);
    sw = 2'b01;
    step(6);
    chk_all("prp_rise2", 2'b01, 2'b01, 2'b00, 2'b00);

    // Both bits together, then bit 1 alone falls
    do_reset(2'b00);
    sw = 2'b11;
    step(6);
    chk_all("indep_rise", 2'b11, 2'b11, 2'b00, 2'b11);
    step(3);
    sw = 2'b01;
    step(6);
    chk_all("indep_fall", 2'b01, 2'b00, 2'b10, 2'b11);

    // Reset in the middle of a pending rise
    do_reset(2'b00);
    sw = 2'b01;
    step(2);
    chk("mid_pre.rise", sw_rise, 2'b00);
    rst_n = 1'b0;
    #1;
    chk_all("mid_in_rst", 2'b00, 2'b00, 2'b00, 2'b00);
    step();
    rst_n = 1'b1;
    step(5);                                     // E0..E4 after release
    chk_all("mid_e4", 2'b00, 2'b00, 2'b00, 2'b00);
    step();
    chk_all("mid_e5", 2'b01, 2'b01, 2'b00, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
